// File: rtl/uart_echo_buffer_if.sv
// Receiver-to-transmitter handshake plus FIFO status bundle for uart_echo_buffer.
// master drives the rx side and tx_busy; slave is the buffer itself.
interface uart_echo_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       rx_data;
  logic             rx_strobe;
  logic             rx_error;
  logic             tx_busy;
  logic             tx_send;
  logic [7:0]       tx_data;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;

  modport master (
    output rx_data, rx_strobe, rx_error, tx_busy,
    input  tx_send, tx_data, count, empty, full, overflow
  );

  modport slave (
    input  rx_data, rx_strobe, rx_error, tx_busy,
    output tx_send, tx_data, count, empty, full, overflow
  );
endinterface

// File: rtl/uart_echo_buffer.sv
// Loopback echo: buffers received bytes in a circular FIFO and drains them to the UART tx.
// Define DROP_ERR_EN to discard bytes that arrive flagged with rx_error.
module uart_echo_buffer #(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic              CLK100MHZ,
  input logic              reset,
  uart_echo_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ACK  = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       state;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic [CNT_W-1:0] count_next;

`ifdef DROP_ERR_EN
  assign push_req = bus.rx_strobe && !bus.rx_error;
`else
  logic unused_rx_error;
  assign unused_rx_error = bus.rx_error;
  assign push_req        = bus.rx_strobe;
`endif

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken then.
  assign pop     = (state == WAIT_DONE) && !bus.tx_busy;
  assign push_ok = push_req && (!bus.full || pop);

  always_comb begin
    count_next = bus.count;
    case ({push_ok, pop})
      2'b10:   count_next = bus.count + CNT_W'(1);
      2'b01:   count_next = bus.count - CNT_W'(1);
      default: count_next = bus.count;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (push_ok) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.count    <= '0;
      bus.empty    <= 1'b1;
      bus.full     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_req && !push_ok) bus.overflow <= 1'b1;
      bus.count <= count_next;
      bus.empty <= (count_next == '0);
      bus.full  <= (count_next == CNT_W'(DEPTH));
    end
  end

  // Drain FSM: the head entry stays in the FIFO until the transmitter reports done.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state       <= IDLE;
      bus.tx_send <= 1'b0;
      bus.tx_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          bus.tx_send <= 1'b0;
          if (!bus.empty && !bus.tx_busy) begin
            bus.tx_data <= mem[rd_ptr];
            bus.tx_send <= 1'b1;
            state       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          bus.tx_send <= 1'b0;
          if (bus.tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          bus.tx_send <= 1'b0;
          if (!bus.tx_busy) state <= IDLE;
        end
        default: begin
          bus.tx_send <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer with a behavioural tx (10-cycle busy) and byte scoreboard.
module tb_uart_echo_buffer;
  logic CLK100MHZ = 1'b0;
  logic reset     = 1'b1;

  uart_echo_buffer_if #(.DEPTH(16)) bus ();

  uart_echo_buffer #(.DEPTH(16)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int       vecs = 0;
  int       fails = 0;
  int       sends = 0;
  int       busy_cnt = 0;
  logic     hold_busy = 1'b0;
  logic [7:0] exp_q [$];

  assign bus.tx_busy = hold_busy || (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Negedge: behave as the transmitter and score sends; then advance to 1 time unit past posedge.
  task automatic step();
    logic [7:0] want;
    @(negedge CLK100MHZ);
    if (bus.tx_send) begin
      sends++;
      chk("send_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("tx_data", {24'd0, bus.tx_data}, {24'd0, want});
      end
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b, input logic err);
    bus.rx_data   = b;
    bus.rx_strobe = 1'b1;
    bus.rx_error  = err;
    step();
    bus.rx_strobe = 1'b0;
    bus.rx_error  = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      if (exp_q.size() == 0 && bus.empty && !bus.tx_busy) done = 1'b1;
    end
    chk("drain_done", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_send();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (bus.tx_send) seen = 1'b1;
    end
    chk("send_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int base;
    bus.rx_data   = 8'h00;
    bus.rx_strobe = 1'b0;
    bus.rx_error  = 1'b0;
    step();
    step();
    chk("rst_tx_send",  {31'd0, bus.tx_send}, 32'd0);
    chk("rst_tx_data",  {24'd0, bus.tx_data}, 32'h00);
    chk("rst_count",    {27'd0, bus.count}, 32'd0);
    chk("rst_empty",    {31'd0, bus.empty}, 32'd1);
    chk("rst_full",     {31'd0, bus.full}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b0;

    // Single byte: count 1 after the strobe edge, send on the following edge.
    exp_q.push_back(8'h41);
    pulse(8'h41, 1'b0);
    chk("t1_count_1", {27'd0, bus.count}, 32'd1);
    step();
    chk("t1_send_latency", {31'd0, bus.tx_send}, 32'd1);
    chk("t1_send_data", {24'd0, bus.tx_data}, 32'h41);
    step(); step(); step();
    chk("t1_count_held", {27'd0, bus.count}, 32'd1);
    chk("t1_send_once", {31'd0, bus.tx_send}, 32'd0);
    drain();
    chk("t1_count_0", {27'd0, bus.count}, 32'd0);
    chk("t1_empty", {31'd0, bus.empty}, 32'd1);
    chk("t1_sends", sends, 32'd1);

    // Burst of four consecutive strobes.
    base = sends;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      pulse(8'h10 + 8'(i), 1'b0);
    end
    chk("t2_count_4", {27'd0, bus.count}, 32'd4);
    drain();
    chk("t2_sends", sends - base, 32'd4);

    // Overfill with tx held busy: 0x10 is dropped.
    hold_busy = 1'b1;
    base = sends;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      pulse(8'(i), 1'b0);
    end
    chk("t3_full", {31'd0, bus.full}, 32'd1);
    chk("t3_count_16", {27'd0, bus.count}, 32'd16);
    chk("t3_overflow", {31'd0, bus.overflow}, 32'd1);
    chk("t3_no_send_busy", sends - base, 32'd0);
    hold_busy = 1'b0;
    drain();
    chk("t3_sends", sends - base, 32'd16);
    chk("t3_overflow_sticky", {31'd0, bus.overflow}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t3_overflow_clr", {31'd0, bus.overflow}, 32'd0);

    // Full FIFO: push of 0xAA coincides with a pop.
    hold_busy = 1'b1;
    base = sends;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      pulse(8'h20 + 8'(i), 1'b0);
    end
    chk("t4_full", {31'd0, bus.full}, 32'd1);
    hold_busy = 1'b0;
    wait_send();
    hold_busy = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("t4_not_removed", {27'd0, bus.count}, 32'd16);
    hold_busy = 1'b0;
    exp_q.push_back(8'hAA);
    pulse(8'hAA, 1'b0);
    chk("t4_count_16", {27'd0, bus.count}, 32'd16);
    chk("t4_full_kept", {31'd0, bus.full}, 32'd1);
    chk("t4_overflow_0", {31'd0, bus.overflow}, 32'd0);
    drain();
    chk("t4_sends", sends - base, 32'd17);

    // Reset while waiting for tx to finish, five entries queued.
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      pulse(8'h30 + 8'(i), 1'b0);
    end
    hold_busy = 1'b0;
    wait_send();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t5_count_5", {27'd0, bus.count}, 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    hold_busy = 1'b0;
    chk("t5_count_0", {27'd0, bus.count}, 32'd0);
    chk("t5_empty", {31'd0, bus.empty}, 32'd1);
    chk("t5_tx_send", {31'd0, bus.tx_send}, 32'd0);
    chk("t5_overflow", {31'd0, bus.overflow}, 32'd0);
    base = sends;
    for (int i = 0; i < 40; i++) step();
    chk("t5_no_sends", sends - base, 32'd0);

    // Error-flagged byte handling.
    base = sends;
`ifdef DROP_ERR_EN
    exp_q.push_back(8'h66);
    pulse(8'h55, 1'b1);
    chk("t6_err_dropped", {27'd0, bus.count}, 32'd0);
    pulse(8'h66, 1'b0);
    chk("t6_count", {27'd0, bus.count}, 32'd1);
    drain();
    chk("t6_sends", sends - base, 32'd1);
    chk("t6_overflow", {31'd0, bus.overflow}, 32'd0);
`else
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    pulse(8'h55, 1'b1);
    chk("t6_err_kept", {27'd0, bus.count}, 32'd1);
    pulse(8'h66, 1'b0);
    chk("t6_count", {27'd0, bus.count}, 32'd2);
    drain();
    chk("t6_sends", sends - base, 32'd2);
    chk("t6_overflow", {31'd0, bus.overflow}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
